// File: rtl/hazard_ctrl.sv
// Data-hazard controller for the RV32I decode stage: per-port forwarding select,
// load-use / memory-wait stall generation, stall watchdog and performance counters.
module hazard_ctrl #(
    parameter  int unsigned NUM_RS     = 2,
    parameter  int unsigned NUM_FWD    = 2,
    parameter  int unsigned LOAD_STAGE = 1,
    parameter  int unsigned TIMEOUT    = 255,
    parameter  int unsigned CNT_W      = 32,
    localparam int unsigned SEL_W      = $clog2(2*NUM_FWD+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_RS*5-1:0]      id_rs,
    input  logic [NUM_RS-1:0]        id_rs_used,
    input  logic [NUM_FWD-1:0]       stg_valid,
    input  logic [NUM_FWD-1:0]       stg_wen,
    input  logic [NUM_FWD*5-1:0]     stg_rd,
    input  logic [NUM_FWD-1:0]       stg_is_load,
    input  logic                     mem_ready,
    input  logic                     flush,
    output logic [NUM_RS*SEL_W-1:0]  fwd_sel,
    output logic                     stall,
    output logic                     hazard_err,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         fwd_events
);

    localparam int unsigned RW    = 5;
    localparam int unsigned RUN_W = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    logic [NUM_FWD-1:0]      w_match [NUM_RS];
    logic [NUM_RS*SEL_W-1:0] w_sel;
    logic [NUM_RS-1:0]       w_haz;
    logic                    w_stall;
    logic                    w_fwd_evt;
    logic                    w_run_entry;
    logic [RUN_W-1:0]        w_run_inc;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [RUN_W-1:0]        r_stall_run;
    logic                    r_hazard_err;
    logic [CNT_W-1:0]        r_stall_cycles;
    logic [CNT_W-1:0]        r_fwd_events;

    // Port p / stage k producer match; x0 never forwards
    always_comb begin
        for (int unsigned p = 0; p < NUM_RS; p++) begin
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                w_match[p][k] = id_valid & id_rs_used[p] & stg_valid[k] & stg_wen[k]
                              & (stg_rd[RW*k +: RW] == id_rs[RW*p +: RW])
                              & (id_rs[RW*p +: RW] != '0);
            end
        end
    end

    // Oldest-to-youngest scan so the youngest matching stage is applied last and wins
    always_comb begin
        w_sel = '0;
        w_haz = '0;
        for (int unsigned p = 0; p < NUM_RS; p++) begin
            for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
                if (w_match[p][k]) begin
                    if (!stg_is_load[k]) begin
                        w_sel[p*SEL_W +: SEL_W] = SEL_W'(2*k + 1);
                        w_haz[p]                = 1'b0;
                    end else if ((k >= int'(LOAD_STAGE)) && mem_ready) begin
                        w_sel[p*SEL_W +: SEL_W] = SEL_W'(2*k + 2);
                        w_haz[p]                = 1'b0;
                    end else begin
                        w_sel[p*SEL_W +: SEL_W] = '0;
                        w_haz[p]                = 1'b1;
                    end
                end
            end
        end
    end

    // Zero-latency outputs, forced quiet while reset is held
    assign w_stall   = rst_n & (|w_haz) & ~flush;
    assign stall     = w_stall;
    assign fwd_sel   = rst_n ? w_sel : '0;
    assign w_fwd_evt = id_valid & ~w_stall & ~flush & (|fwd_sel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_stall)  w_state_nxt = ST_STALL;
            ST_STALL: if (!w_stall) w_state_nxt = ST_RUN;
            default:                w_state_nxt = ST_RUN;
        endcase
        if (flush) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        w_run_entry = 1'b0;
        if ((r_state == ST_STALL) && (w_state_nxt == ST_RUN)) begin
            w_run_entry = 1'b1;
        end
    end

    assign w_run_inc = (r_stall_run == '1) ? r_stall_run : r_stall_run + RUN_W'(1);

    // Current stall length; the watchdog compares the post-increment value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_run  <= '0;
            r_hazard_err <= 1'b0;
        end else begin
            if (w_run_entry) begin
                r_stall_run <= '0;
            end else if (w_stall) begin
                r_stall_run <= w_run_inc;
            end
            if (w_stall && (32'(w_run_inc) >= TIMEOUT)) begin
                r_hazard_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_fwd_events   <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_fwd_evt && (r_fwd_events != '1)) begin
                r_fwd_events <= r_fwd_events + CNT_W'(1);
            end
        end
    end

    assign hazard_err   = r_hazard_err;
    assign stall_cycles = r_stall_cycles;
    assign fwd_events   = r_fwd_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two configurations share one stimulus stream,
// expectations come from a rule-level reference model and are checked at negedge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [8:0]  sel;
        logic        stall;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fe;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, id_valid, mem_ready, flush;
    logic [2:0][4:0] rs, rd;
    logic [2:0]      used, sv, sw, sl;

    logic [5:0]  a_sel;
    logic        a_stall, a_err;
    logic [31:0] a_sc, a_fe;
    logic [8:0]  b_sel;
    logic        b_stall, b_err;
    logic [3:0]  b_sc, b_fe;

    hazard_ctrl #(.NUM_RS(2), .NUM_FWD(2), .LOAD_STAGE(1), .TIMEOUT(3), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(rs[1:0]),
        .id_rs_used(used[1:0]), .stg_valid(sv[1:0]), .stg_wen(sw[1:0]), .stg_rd(rd[1:0]),
        .stg_is_load(sl[1:0]), .mem_ready(mem_ready), .flush(flush), .fwd_sel(a_sel),
        .stall(a_stall), .hazard_err(a_err), .stall_cycles(a_sc), .fwd_events(a_fe)
    );

    hazard_ctrl #(.NUM_RS(3), .NUM_FWD(3), .LOAD_STAGE(2), .TIMEOUT(1), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(rs),
        .id_rs_used(used), .stg_valid(sv), .stg_wen(sw), .stg_rd(rd),
        .stg_is_load(sl), .mem_ready(mem_ready), .flush(flush), .fwd_sel(b_sel),
        .stall(b_stall), .hazard_err(b_err), .stall_cycles(b_sc), .fwd_events(b_fe)
    );

    exp_t   qa[$];
    exp_t   qb[$];
    longint m_sr[2], m_sc[2], m_fe[2];
    bit     m_err[2];
    int     n_chk = 0;
    int     n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference rules: first matching stage from the youngest; returns {stall, sel[3 ports]}
    function automatic logic [9:0] ref_comb(input int nrs, input int nfwd, input int ls);
        logic [8:0] sel;
        logic       haz;
        int         win;
        sel = '0;
        haz = 1'b0;
        if (!rst_n) return 10'd0;
        for (int p = 0; p < nrs; p++) begin
            win = -1;
            if (id_valid && used[p] && rs[p] != 5'd0) begin
                for (int k = 0; k < nfwd; k++) begin
                    if (sv[k] && sw[k] && rd[k] == rs[p]) begin
                        win = k;
                        break;
                    end
                end
            end
            if (win >= 0) begin
                if (!sl[win])                     sel[3*p +: 3] = 3'(2*win + 1);
                else if (win >= ls && mem_ready)  sel[3*p +: 3] = 3'(2*win + 2);
                else                              haz = 1'b1;
            end
        end
        return {haz & ~flush, sel};
    endfunction

    task automatic model_edge(input int i, input logic [9:0] c, input longint to, input int cw);
        longint mx;
        mx = (longint'(1) << cw) - 1;
        if (!rst_n) begin
            m_sr[i] = 0; m_sc[i] = 0; m_fe[i] = 0; m_err[i] = 0;
            return;
        end
        if (c[9]) begin
            if (m_sr[i] < 65535) m_sr[i]++;
            if (m_sr[i] >= to)   m_err[i] = 1;
            if (m_sc[i] < mx)    m_sc[i]++;
        end else begin
            m_sr[i] = 0;
        end
        if (id_valid && !c[9] && !flush && c[8:0] != 9'd0 && m_fe[i] < mx) m_fe[i]++;
    endtask

    // One cycle: expected outputs for the current inputs plus pre-edge register values
    task automatic step(input bit push);
        logic [9:0] ca, cb;
        exp_t       ea, eb;
        ca = ref_comb(2, 2, 1);
        cb = ref_comb(3, 3, 2);
        ea.sel = ca[8:0]; ea.stall = ca[9]; ea.err = m_err[0];
        ea.sc = 32'(m_sc[0]); ea.fe = 32'(m_fe[0]);
        eb.sel = cb[8:0]; eb.stall = cb[9]; eb.err = m_err[1];
        eb.sc = 32'(m_sc[1]); eb.fe = 32'(m_fe[1]);
        if (push) begin
            qa.push_back(ea);
            qb.push_back(eb);
        end
        model_edge(0, ca, 3, 32);
        model_edge(1, cb, 1, 4);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; rs = '0; rd = '0; used = '0;
        sv = '0; sw = '0; sl = '0; mem_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic stage(input int k, input int r, input bit ld);
        sv[k] = 1'b1; sw[k] = 1'b1; rd[k] = 5'(r); sl[k] = ld;
    endtask

    task automatic dec(input int r0, input int r1, input int r2);
        id_valid = 1'b1; used = 3'b111;
        rs[0] = 5'(r0); rs[1] = 5'(r1); rs[2] = 5'(r2);
    endtask

    task automatic rnd();
        id_valid  = ($urandom_range(0, 7) != 0);
        for (int p = 0; p < 3; p++) begin
            rs[p]   = 5'($urandom_range(0, 3));
            used[p] = ($urandom_range(0, 4) != 0);
        end
        for (int k = 0; k < 3; k++) begin
            sv[k] = ($urandom_range(0, 4) != 0);
            sw[k] = ($urandom_range(0, 4) != 0);
            rd[k] = 5'($urandom_range(0, 3));
            sl[k] = ($urandom_range(0, 2) == 0);
        end
        mem_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 15) == 0);
        rst_n     = ($urandom_range(0, 99) != 0);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            chk("A.fwd_sel", 64'(a_sel), 64'(e.sel[5:0]));
            chk("A.stall", 64'(a_stall), 64'(e.stall));
            chk("A.hazard_err", 64'(a_err), 64'(e.err));
            chk("A.stall_cycles", 64'(a_sc), 64'(e.sc));
            chk("A.fwd_events", 64'(a_fe), 64'(e.fe));
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (qb.size() != 0) begin
            e = qb.pop_front();
            chk("B.fwd_sel", 64'(b_sel), 64'(e.sel));
            chk("B.stall", 64'(b_stall), 64'(e.stall));
            chk("B.hazard_err", 64'(b_err), 64'(e.err));
            chk("B.stall_cycles", 64'(b_sc), 64'(e.sc[3:0]));
            chk("B.fwd_events", 64'(b_fe), 64'(e.fe[3:0]));
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step(0);
        step(0);
        rst_n = 1'b1;

        // EX forwarding on port0 only
        idle(); stage(0, 5, 0); dec(5, 6, 0); step(1);
        // youngest wins, then the older load is taken
        idle(); stage(0, 5, 0); stage(1, 5, 1); dec(5, 0, 0); step(1);
        sv[0] = 1'b0; step(1);
        // load-use then resolved from MEM
        idle(); stage(0, 7, 1); dec(0, 7, 0); step(1);
        idle(); stage(1, 7, 1); dec(0, 7, 0); step(1);
        // memory wait long enough to trip the watchdog
        idle(); stage(1, 9, 1); dec(9, 0, 0); mem_ready = 1'b0;
        repeat (4) step(1);
        mem_ready = 1'b1; step(1);
        idle(); step(1);
        // x0 and unused port
        idle(); stage(0, 0, 0); dec(0, 0, 0); step(1);
        idle(); stage(0, 3, 0); dec(0, 3, 0); used = 3'b101; step(1);
        // flush over a hazard, then reset in the middle of a stall
        idle(); stage(0, 7, 1); dec(7, 0, 0); flush = 1'b1; step(1);
        flush = 1'b0; step(1); step(1);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; idle(); step(1);
        // third stage: ALU, ready load, waiting load
        idle(); stage(2, 12, 0); dec(0, 0, 12); step(1);
        sl[2] = 1'b1; step(1);
        mem_ready = 1'b0; step(1);
        idle(); step(1);

        repeat (1500) begin
            rnd();
            step(1);
        end
        rst_n = 1'b1;
        idle();
        step(1);

        repeat (2) @(negedge clk);
        #1;
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
